// File: rtl/itch_stream_arbiter.sv
// Two-source AXI-Stream message arbiter in front of the ITCH parser.
// Whole messages are granted round-robin and capped at C_MAX_MSG_LEN beats.
// Define ITCH_ARB_STATS_EN to build the message and truncation counters.
module itch_stream_arbiter #(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int C_MAX_MSG_LEN      = 64
) (
   input  logic                          s00_axis_aclk,
   input  logic                          s00_axis_aresetn,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                          s00_axis_tvalid,
   input  logic                          s00_axis_tlast,
   output logic                          s00_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
   input  logic                          s01_axis_tvalid,
   input  logic                          s01_axis_tlast,
   output logic                          s01_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic                          m00_axis_tvalid,
   output logic                          m00_axis_tlast,
   input  logic                          m00_axis_tready,
   output logic [1:0]                    grant,
   output logic                          err_trunc,
   output logic [31:0]                   msg_cnt0,
   output logic [31:0]                   msg_cnt1,
   output logic [31:0]                   trunc_cnt
);

   typedef enum logic [2:0] {IDLE, PORT0, PORT1, DRAIN0, DRAIN1} state_t;

   localparam logic [7:0] LAST_IDX = 8'(C_MAX_MSG_LEN - 1);

   state_t                          state, state_nxt;
   logic                            last_grant;
   logic [7:0]                      beat_cnt;
   logic                            out_free;
   logic                            fwd, fwd_last, trunc, done;
   logic                            drain_end;
   logic [C_AXIS_TDATA_WIDTH-1:0]   fwd_data;

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) state <= IDLE;
      else                   state <= state_nxt;
   end

   // Datapath decode of the beat being accepted this cycle
   always_comb begin
      fwd       = (state == PORT0 && s00_axis_tvalid && s00_axis_tready) ||
                  (state == PORT1 && s01_axis_tvalid && s01_axis_tready);
      fwd_data  = (state == PORT1) ? s01_axis_tdata : s00_axis_tdata;
      fwd_last  = (state == PORT1) ? s01_axis_tlast : s00_axis_tlast;
      trunc     = fwd && !fwd_last && (beat_cnt == LAST_IDX);
      done      = fwd && (fwd_last || trunc);
      drain_end = (state == DRAIN0 && s00_axis_tvalid && s00_axis_tlast) ||
                  (state == DRAIN1 && s01_axis_tvalid && s01_axis_tlast);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // last_grant=1 means port 1 went last, so port 0 wins a tie
            if (s00_axis_tvalid && (!s01_axis_tvalid || last_grant)) state_nxt = PORT0;
            else if (s01_axis_tvalid)                                  state_nxt = PORT1;
         end
         PORT0: begin
            if (trunc)     state_nxt = DRAIN0;
            else if (done) state_nxt = IDLE;
         end
         PORT1: begin
            if (trunc)     state_nxt = DRAIN1;
            else if (done) state_nxt = IDLE;
         end
         DRAIN0, DRAIN1: begin
            if (drain_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant           = '0;
      s00_axis_tready = 1'b0;
      s01_axis_tready = 1'b0;
      out_free        = !m00_axis_tvalid || m00_axis_tready;
      case (state)
         PORT0:   begin grant = 2'b01; s00_axis_tready = out_free; end
         PORT1:   begin grant = 2'b10; s01_axis_tready = out_free; end
         DRAIN0:  begin grant = 2'b01; s00_axis_tready = 1'b1;     end
         DRAIN1:  begin grant = 2'b10; s01_axis_tready = 1'b1;     end
         default: ;
      endcase
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         last_grant      <= 1'b1;
         beat_cnt        <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tdata  <= '0;
         err_trunc       <= 1'b0;
      end else begin
         err_trunc <= trunc;
         if (state == IDLE && state_nxt != IDLE) beat_cnt <= '0;
         else if (fwd)                           beat_cnt <= beat_cnt + 8'd1;
         if (done) last_grant <= (state == PORT1);
         if (fwd) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= fwd_data;
            m00_axis_tlast  <= fwd_last || trunc;
         end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
         end
      end
   end

`ifdef ITCH_ARB_STATS_EN
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         msg_cnt0  <= '0;
         msg_cnt1  <= '0;
         trunc_cnt <= '0;
      end else begin
         if (done && state == PORT0) msg_cnt0  <= msg_cnt0 + 32'd1;
         if (done && state == PORT1) msg_cnt1  <= msg_cnt1 + 32'd1;
         if (trunc)                  trunc_cnt <= trunc_cnt + 32'd1;
      end
   end
`else
   always_comb begin
      msg_cnt0  = '0;
      msg_cnt1  = '0;
      trunc_cnt = '0;
   end
`endif

endmodule

// File: tb/tb_itch_stream_arbiter.sv
// Bench for itch_stream_arbiter: message-level reference model, one DUT at the
// default length cap and one capped at 8 beats, both fed the same stimulus.
module tb_itch_stream_arbiter;
   localparam int W     = 32;
   localparam int LIMIT = 3000;
`ifdef ITCH_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [W-1:0] s_data [2];
   logic [1:0]   s_valid, s_last;
   logic         m_ready;
   logic         sel;

   logic [1:0]   a_rdy, b_rdy, a_grant, b_grant;
   logic [W-1:0] a_data, b_data;
   logic         a_valid, a_last, a_err, b_valid, b_last, b_err;
   logic [31:0]  a_c0, a_c1, a_ct, b_c0, b_c1, b_ct;

   logic [1:0]   o_rdy, o_grant;
   logic [W-1:0] o_data;
   logic         o_valid, o_last, o_err;
   logic [31:0]  o_c0, o_c1, o_ct;

   always #5 clk = ~clk;

   itch_stream_arbiter #(.C_AXIS_TDATA_WIDTH(W), .C_MAX_MSG_LEN(64)) dut (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tdata(s_data[0]), .s00_axis_tvalid(s_valid[0]), .s00_axis_tlast(s_last[0]),
      .s00_axis_tready(a_rdy[0]),
      .s01_axis_tdata(s_data[1]), .s01_axis_tvalid(s_valid[1]), .s01_axis_tlast(s_last[1]),
      .s01_axis_tready(a_rdy[1]),
      .m00_axis_tdata(a_data), .m00_axis_tvalid(a_valid), .m00_axis_tlast(a_last),
      .m00_axis_tready(m_ready), .grant(a_grant), .err_trunc(a_err),
      .msg_cnt0(a_c0), .msg_cnt1(a_c1), .trunc_cnt(a_ct));

   itch_stream_arbiter #(.C_AXIS_TDATA_WIDTH(W), .C_MAX_MSG_LEN(8)) dut8 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tdata(s_data[0]), .s00_axis_tvalid(s_valid[0]), .s00_axis_tlast(s_last[0]),
      .s00_axis_tready(b_rdy[0]),
      .s01_axis_tdata(s_data[1]), .s01_axis_tvalid(s_valid[1]), .s01_axis_tlast(s_last[1]),
      .s01_axis_tready(b_rdy[1]),
      .m00_axis_tdata(b_data), .m00_axis_tvalid(b_valid), .m00_axis_tlast(b_last),
      .m00_axis_tready(m_ready), .grant(b_grant), .err_trunc(b_err),
      .msg_cnt0(b_c0), .msg_cnt1(b_c1), .trunc_cnt(b_ct));

   assign o_rdy   = sel ? b_rdy   : a_rdy;
   assign o_grant = sel ? b_grant : a_grant;
   assign o_data  = sel ? b_data  : a_data;
   assign o_valid = sel ? b_valid : a_valid;
   assign o_last  = sel ? b_last  : a_last;
   assign o_err   = sel ? b_err   : a_err;
   assign o_c0    = sel ? b_c0    : a_c0;
   assign o_c1    = sel ? b_c1    : a_c1;
   assign o_ct    = sel ? b_ct    : a_ct;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: per-port source beats and per-port expected output beats ({last, data})
   logic [W:0] src_q [2][$];
   logic [W:0] exp_q [2][$];
   int         exp_msgs [2];
   int         exp_trunc, err_seen, seq, cur_p;
   logic       in_msg;
   int         log_cyc [$];
   int         log_p [$];
   logic [1:0] log_g [$];

   task automatic add_msg(input int p, input int len, input int max_len);
      int n;
      logic [W:0] b;
      n = (len > max_len) ? max_len : len;
      for (int i = 0; i < len; i++) begin
         b[W-1:0] = {8'(p), 8'(seq), 8'h00, (i == 0) ? 8'h44 : 8'(i)};
         b[W]     = (i == len - 1);
         src_q[p].push_back(b);
         if (i < n) begin
            b[W] = (i == n - 1);
            exp_q[p].push_back(b);
         end
      end
      exp_msgs[p]++;
      if (len > max_len) exp_trunc++;
      seq++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_valid = '0; s_last = '0; s_data[0] = '0; s_data[1] = '0; m_ready = 1'b0;
      for (int p = 0; p < 2; p++) begin
         src_q[p].delete(); exp_q[p].delete(); exp_msgs[p] = 0;
      end
      exp_trunc = 0; err_seen = 0; in_msg = 1'b0; cur_p = 0;
      log_cyc.delete(); log_p.delete(); log_g.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives both sources and the sink, checking every m00 beat against the model
   task automatic run_traffic(input int ready_mode, input int gap_pct, input int stop0);
      int cyc, taken0, pi;
      logic prev_stall;
      logic [W:0] prev_out;
      logic [1:0] held;
      cyc = 0; taken0 = 0; prev_stall = 1'b0; prev_out = '0; held = '0;
      while (cyc < LIMIT) begin
         if (stop0 < 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (src_q[p].size() == 0) begin
               s_valid[p] = 1'b0; held[p] = 1'b0;
            end else begin
               if (!held[p]) held[p] = ($urandom_range(99) >= gap_pct);
               s_valid[p] = held[p];
               s_data[p]  = src_q[p][0][W-1:0];
               s_last[p]  = src_q[p][0][W];
            end
         end
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(3) != 0);
            default: m_ready = (cyc % 2 == 0);
         endcase
         #1;
         if (prev_stall) begin
            n_checks++;
            if ({o_valid, o_last, o_data} !== {1'b1, prev_out})
               $display("FAIL stall_hold: got v=%0b last=%0b data=%h, expected v=1 last=%0b data=%h",
                        o_valid, o_last, o_data, prev_out[W], prev_out[W-1:0]);
            else n_pass++;
         end
         if (o_valid && m_ready) begin
            pi = int'(o_data[24]);
            n_checks++;
            if (o_data[31:25] != 0 || exp_q[pi].size() == 0 || (in_msg && pi != cur_p))
               $display("FAIL beat_owner: got data=%h last=%0b, expected a beat of port %0d",
                        o_data, o_last, in_msg ? cur_p : pi);
            else if ({o_last, o_data} !== exp_q[pi][0])
               $display("FAIL beat: got last=%0b data=%h, expected last=%0b data=%h",
                        o_last, o_data, exp_q[pi][0][W], exp_q[pi][0][W-1:0]);
            else n_pass++;
            if (exp_q[pi].size() > 0) void'(exp_q[pi].pop_front());
            in_msg = !o_last; cur_p = pi;
            log_cyc.push_back(cyc); log_p.push_back(pi); log_g.push_back(o_grant);
         end
         prev_stall = o_valid && !m_ready;
         prev_out   = {o_last, o_data};
         if (o_err) err_seen++;
         for (int p = 0; p < 2; p++) begin
            if (s_valid[p] && o_rdy[p]) begin
               void'(src_q[p].pop_front());
               held[p] = 1'b0;
               if (p == 0) taken0++;
            end
         end
         cyc++;
         if (stop0 >= 0 && taken0 >= stop0) break;
      end
      n_checks++;
      if (cyc >= LIMIT) $display("FAIL traffic_timeout: got %0d cycles, expected fewer than %0d", cyc, LIMIT);
      else n_pass++;
   endtask

   task automatic check_stats(input string name);
      n_checks++;
      if ({o_c0, o_c1, o_ct} !== {STATS ? 32'(exp_msgs[0]) : 32'd0,
                                  STATS ? 32'(exp_msgs[1]) : 32'd0,
                                  STATS ? 32'(exp_trunc)   : 32'd0})
         $display("FAIL %s_stats: got %0d/%0d/%0d, expected %0d/%0d/%0d", name, o_c0, o_c1, o_ct,
                  STATS ? exp_msgs[0] : 0, STATS ? exp_msgs[1] : 0, STATS ? exp_trunc : 0);
      else n_pass++;
      n_checks++;
      if (err_seen !== exp_trunc)
         $display("FAIL %s_err_pulses: got %0d, expected %0d", name, err_seen, exp_trunc);
      else n_pass++;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      rst_n = 1'b0; s_valid = '0; s_last = '0; s_data[0] = '0; s_data[1] = '0; m_ready = 1'b1;
      #1;
      n_checks++;
      if ({o_valid, o_last, o_data, o_grant, o_err, o_rdy, o_c0, o_c1, o_ct} !== '0)
         $display("FAIL reset_outputs: got v=%0b l=%0b d=%h g=%b e=%0b r=%b, expected all zero",
                  o_valid, o_last, o_data, o_grant, o_err, o_rdy);
      else n_pass++;
      do_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({o_valid, o_grant, o_rdy} !== '0)
         $display("FAIL idle_no_valid: got v=%0b g=%b r=%b, expected 0 00 00", o_valid, o_grant, o_rdy);
      else n_pass++;
   endtask

   task automatic test_d_message();
      sel = 1'b0;
      do_reset();
      add_msg(0, 9, 64);
      run_traffic(0, 0, -1);
      n_checks++;
      if (log_cyc.size() !== 9) $display("FAIL d_msg_count: got %0d beats, expected 9", log_cyc.size());
      else begin
         n_pass++;
         n_checks++;
         if (log_cyc[8] - log_cyc[0] !== 8)
            $display("FAIL d_msg_consecutive: got span %0d, expected 8", log_cyc[8] - log_cyc[0]);
         else n_pass++;
         n_checks++;
         if (log_cyc[0] !== 2) $display("FAIL d_msg_latency: got cycle %0d, expected 2", log_cyc[0]);
         else n_pass++;
         n_checks++;
         if (log_g[0] !== 2'b01) $display("FAIL d_msg_grant: got %b, expected 01", log_g[0]);
         else n_pass++;
      end
      check_stats("d_msg");
   endtask

   task automatic test_tie();
      sel = 1'b0;
      do_reset();
      add_msg(0, 9, 64);
      add_msg(1, 9, 64);
      run_traffic(0, 0, -1);
      n_checks++;
      if (log_p.size() !== 18) $display("FAIL tie_count: got %0d beats, expected 18", log_p.size());
      else begin
         n_pass++;
         for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (log_p[i] !== ((i < 9) ? 0 : 1))
               $display("FAIL tie_order: beat %0d got port %0d, expected %0d", i, log_p[i], (i < 9) ? 0 : 1);
            else n_pass++;
         end
         n_checks++;
         if (log_cyc[9] - log_cyc[8] !== 2)
            $display("FAIL tie_bubble: got gap %0d, expected 2", log_cyc[9] - log_cyc[8]);
         else n_pass++;
      end
      check_stats("tie");
   endtask

   task automatic test_stall();
      sel = 1'b0;
      do_reset();
      add_msg(1, 9, 64);
      run_traffic(2, 0, -1);
      n_checks++;
      if (log_p.size() !== 9) $display("FAIL stall_count: got %0d beats, expected 9", log_p.size());
      else n_pass++;
      check_stats("stall");
   endtask

   task automatic test_truncation();
      sel = 1'b1;
      do_reset();
      add_msg(0, 12, 8);
      add_msg(0, 8, 8);
      run_traffic(0, 0, -1);
      n_checks++;
      if (log_p.size() !== 16) $display("FAIL trunc_count: got %0d beats, expected 16", log_p.size());
      else n_pass++;
      check_stats("trunc");
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      do_reset();
      add_msg(0, 9, 64);
      run_traffic(0, 0, 4);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_last, o_data, o_grant, o_err, o_rdy, o_c0, o_c1, o_ct} !== '0)
         $display("FAIL reset_mid_outputs: got v=%0b l=%0b d=%h g=%b e=%0b r=%b, expected all zero",
                  o_valid, o_last, o_data, o_grant, o_err, o_rdy);
      else n_pass++;
      do_reset();
      add_msg(0, 9, 64);
      run_traffic(0, 0, -1);
      n_checks++;
      if (log_p.size() !== 9) $display("FAIL reset_mid_after: got %0d beats, expected 9", log_p.size());
      else n_pass++;
      check_stats("reset_mid");
   endtask

   task automatic test_random();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         do_reset();
         for (int k = 0; k < 14; k++)
            add_msg(int'($urandom_range(1)), int'($urandom_range(s ? 12 : 20, 1)), s ? 8 : 64);
         run_traffic(1, 30, -1);
         check_stats(s ? "random8" : "random64");
      end
   endtask

   initial begin
      test_reset();
      test_d_message();
      test_tie();
      test_stall();
      test_truncation();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
